// File: rtl/fixed_point_divider.sv
// Iterative signed fixed-point divider: q = (a << FRAC_BITS) / b, truncated toward zero, one bit per cycle.
// Optional macro DIVIDER_SATURATE_EN clamps q on overflow and divide-by-zero.
module fixed_point_divider #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned ITER  = WIDTH + FRAC_BITS;
  localparam int unsigned CNT_W = $clog2(ITER + 1);
  localparam logic [ITER-1:0] NEG_LIM = ITER'(1) << (WIDTH - 1);
  localparam logic [ITER-1:0] POS_LIM = NEG_LIM - ITER'(1);
`ifdef DIVIDER_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e             state_q, state_d;
  logic [ITER-1:0]    num_q, num_d;
  logic [ITER-1:0]    mag_q, mag_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   bmag_q, bmag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic               dz_q, dz_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;
`ifdef DIVIDER_SATURATE_EN
  logic               neg_a_q, neg_a_d;
`endif

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     rem_shift;
  logic               ovf_c;

  // Magnitudes wrap naturally so the most negative value maps onto itself
  assign abs_a     = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign abs_b     = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  assign rem_shift = {rem_q, num_q[ITER-1]};
  assign ovf_c     = !dz_q && (sign_q ? (mag_q > NEG_LIM) : (mag_q > POS_LIM));

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    mag_d       = mag_q;
    rem_d       = rem_q;
    bmag_d      = bmag_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    dz_d        = dz_q;
    q_d         = q_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
`ifdef DIVIDER_SATURATE_EN
    neg_a_d     = neg_a_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          bmag_d  = abs_b;
          // Zero dividend is forced positive so it never wraps to -0
          sign_d  = (a[WIDTH-1] ^ b[WIDTH-1]) && (a != '0);
          dz_d    = (b == '0);
          rem_d   = '0;
          mag_d   = '0;
          num_d   = {abs_a, FRAC_BITS'(0)};
          cnt_d   = CNT_W'(ITER);
`ifdef DIVIDER_SATURATE_EN
          neg_a_d = a[WIDTH-1];
`endif
          state_d = CALC;
        end
      end
      CALC: begin
        num_d = num_q << 1;
        if (rem_shift >= {1'b0, bmag_q}) begin
          rem_d = rem_shift[WIDTH-1:0] - bmag_q;
          mag_d = {mag_q[ITER-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
          mag_d = {mag_q[ITER-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        q_d   = sign_q ? (WIDTH'(0) - mag_q[WIDTH-1:0]) : mag_q[WIDTH-1:0];
`ifdef DIVIDER_SATURATE_EN
        if (dz_q)       q_d = neg_a_q ? SAT_NEG : SAT_POS;
        else if (ovf_c) q_d = sign_q ? SAT_NEG : SAT_POS;
`else
        if (dz_q)       q_d = '0;
`endif
        dbz_d   = dz_q;
        ovf_d   = ovf_c;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      num_q       <= '0;
      mag_q       <= '0;
      rem_q       <= '0;
      bmag_q      <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef DIVIDER_SATURATE_EN
      neg_a_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      mag_q       <= mag_d;
      rem_q       <= rem_d;
      bmag_q      <= bmag_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      dz_q        <= dz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      q_q         <= q_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
`ifdef DIVIDER_SATURATE_EN
      neg_a_q     <= neg_a_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign q           = q_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed self-checking bench for fixed_point_divider (Q8.8 default); honours DIVIDER_SATURATE_EN.
module tb_fixed_point_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
  logic        div_by_zero;
  logic        overflow;

  int checks;
  int failures;

  localparam int LAT = 25;

  fixed_point_divider #(.WIDTH(16), .FRAC_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operation and reports latency and the presented result; lat=-1 if never accepted or never answered
  task automatic issue_op(input logic [15:0] ai, input logic [15:0] bi, output int lat,
                          output logic [15:0] qo, output logic dzo, output logic ovo);
    int waited;
    lat = -1; qo = 'x; dzo = 1'bx; ovo = 1'bx;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) return;
    a = ai; b = bi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) return;
    qo = q; dzo = div_by_zero; ovo = overflow;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    checks++;
    if (q !== 16'h0000 || div_by_zero !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: q=%h dz=%b ovf=%b required 0000/0/0", q, div_by_zero, overflow);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [15:0] va [4] = '{16'h0300, 16'hFD00, 16'h0100, 16'hFF00};
    logic [15:0] vb [4] = '{16'h0200, 16'h0200, 16'h0300, 16'h0300};
    logic [15:0] vq [4] = '{16'h0180, 16'hFE80, 16'h0055, 16'hFFAB};
    int lat; logic [15:0] qo; logic dzo, ovo;
    for (int i = 0; i < 4; i++) begin
      issue_op(va[i], vb[i], lat, qo, dzo, ovo);
      checks++;
      if (lat !== LAT) begin
        failures++;
        $display("FAIL basic_latency[%0d]: got %0d edges required %0d", i, lat, LAT);
      end
      checks++;
      if (qo !== vq[i] || dzo !== 1'b0 || ovo !== 1'b0) begin
        failures++;
        $display("FAIL basic_result[%0d]: a=%h b=%h q=%h dz=%b ovf=%b required %h/0/0",
                 i, va[i], vb[i], qo, dzo, ovo, vq[i]);
      end
    end
  endtask

  task automatic test_overflow;
    int lat; logic [15:0] qo, e1, e2; logic dzo, ovo;
`ifdef DIVIDER_SATURATE_EN
    e1 = 16'h7FFF; e2 = 16'h7FFF;
`else
    e1 = 16'hFE00; e2 = 16'h8000;
`endif
    issue_op(16'h7F00, 16'h0080, lat, qo, dzo, ovo);
    checks++;
    if (qo !== e1 || ovo !== 1'b1 || dzo !== 1'b0) begin
      failures++;
      $display("FAIL overflow_pos: q=%h ovf=%b dz=%b required %h/1/0", qo, ovo, dzo, e1);
    end
    issue_op(16'h8000, 16'hFF00, lat, qo, dzo, ovo);
    checks++;
    if (qo !== e2 || ovo !== 1'b1 || dzo !== 1'b0) begin
      failures++;
      $display("FAIL overflow_minneg: q=%h ovf=%b dz=%b required %h/1/0", qo, ovo, dzo, e2);
    end
    // Exactly -128.0 is representable and must not flag
    issue_op(16'h8000, 16'h0100, lat, qo, dzo, ovo);
    checks++;
    if (qo !== 16'h8000 || ovo !== 1'b0 || dzo !== 1'b0) begin
      failures++;
      $display("FAIL overflow_edge: q=%h ovf=%b dz=%b required 8000/0/0", qo, ovo, dzo);
    end
  endtask

  task automatic test_div_by_zero;
    int lat; logic [15:0] qo, e1, e2; logic dzo, ovo;
`ifdef DIVIDER_SATURATE_EN
    e1 = 16'h8000; e2 = 16'h7FFF;
`else
    e1 = 16'h0000; e2 = 16'h0000;
`endif
    issue_op(16'hFE00, 16'h0000, lat, qo, dzo, ovo);
    checks++;
    if (lat !== LAT) begin
      failures++;
      $display("FAIL dz_latency: got %0d edges required %0d", lat, LAT);
    end
    checks++;
    if (qo !== e1 || dzo !== 1'b1 || ovo !== 1'b0) begin
      failures++;
      $display("FAIL dz_neg: q=%h dz=%b ovf=%b required %h/1/0", qo, dzo, ovo, e1);
    end
    issue_op(16'h0000, 16'h0000, lat, qo, dzo, ovo);
    checks++;
    if (qo !== e2 || dzo !== 1'b1 || ovo !== 1'b0) begin
      failures++;
      $display("FAIL dz_zero: q=%h dz=%b ovf=%b required %h/1/0", qo, dzo, ovo, e2);
    end
  endtask

  task automatic test_zero_dividend;
    int lat; logic [15:0] qo; logic dzo, ovo;
    issue_op(16'h0000, 16'hFE00, lat, qo, dzo, ovo);
    checks++;
    if (qo !== 16'h0000 || dzo !== 1'b0 || ovo !== 1'b0) begin
      failures++;
      $display("FAIL zero_dividend: q=%h dz=%b ovf=%b required 0000/0/0", qo, dzo, ovo);
    end
  endtask

  task automatic test_back_to_back;
    int lat; bit seen; logic [15:0] held_q; logic held_dz, held_ov;
    @(negedge clk);
    a = 16'h0300; b = 16'h0200; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(posedge clk); #1;
      seen = out_valid;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL bp_first_valid: out_valid never rose");
    end
    held_q = q; held_dz = div_by_zero; held_ov = overflow;
    checks++;
    if (held_q !== 16'h0180) begin
      failures++;
      $display("FAIL bp_first_q: q=%h required 0180", held_q);
    end
    a = 16'h0100; b = 16'h0300; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (q !== held_q || div_by_zero !== held_dz || overflow !== held_ov
          || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: q=%h dz=%b ovf=%b ov=%b ir=%b required %h/%b/%b/1/0",
                 c, q, div_by_zero, overflow, out_valid, in_ready, held_q, held_dz, held_ov);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    // in_valid still held: the second operation is accepted on this edge
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat !== LAT || q !== 16'h0055) begin
      failures++;
      $display("FAIL bp_second: lat=%0d q=%h required %0d/0055", lat, q, LAT);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int lat; bit stray; logic [15:0] qo; logic dzo, ovo;
    @(negedge clk);
    a = 16'h0300; b = 16'h0200; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_async: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) stray = 1;
    end
    checks++;
    if (stray) begin
      failures++;
      $display("FAIL mid_reset_discard: out_valid=1 observed required 0");
    end
    issue_op(16'h0100, 16'h0100, lat, qo, dzo, ovo);
    checks++;
    if (lat !== LAT || qo !== 16'h0100 || dzo !== 1'b0 || ovo !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_after: lat=%0d q=%h dz=%b ovf=%b required %0d/0100/0/0",
               lat, qo, dzo, ovo, LAT);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_div_by_zero();
    test_zero_dividend();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fixed_point_divider.md
Name: fixed_point_divider

Overview:
- Iterative signed fixed-point divider; the inverse operation of the team's combinational Q8.8 Multiplier.
- Computes q = (a << FRAC_BITS) / b, truncated toward zero, at one quotient bit per cycle (restoring algorithm).
- Uses a valid/ready handshake on both sides so it can sit in the datapath alongside the Multiplier.
- Reports divide-by-zero and overflow.

Parameters:
- WIDTH, 16: operand and result width, two's complement.
- FRAC_BITS, 8: fractional bits (default is Q8.8).

Ports:
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous active-low reset.
- in_valid  in  1: operands present.
- in_ready  out  1: divider idle, can accept.
- a  in  WIDTH: dividend.
- b  in  WIDTH: divisor.
- out_valid  out  1: result present.
- out_ready  in  1: consumer accepts result.
- q  out  WIDTH: quotient.
- div_by_zero  out  1: b was 0; qualified by out_valid.
- overflow  out  1: quotient magnitude unrepresentable; qualified by out_valid.

Behaviour:
- Reset (asynchronous, rst_n=0) forces:
  - state=IDLE, in_ready=1, out_valid=0.
  - q=0, div_by_zero=0, overflow=0.
  - All internal registers cleared.
- Reset mid-operation: the in-flight operation is discarded; no output is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready edge, latch:
    - |a|, |b| as WIDTH-bit unsigned magnitudes (0x8000 maps to 0x8000).
    - sign = a[MSB]^b[MSB].
    - dz = (b==0).
  - Clear the remainder; load the numerator = |a| << FRAC_BITS (WIDTH+FRAC_BITS bits).
  - Load the iteration counter with ITER = WIDTH+FRAC_BITS (24 by default).
  - Go to CALC.
- CALC:
  - Each cycle: shift the remainder left and bring in the numerator MSB.
  - If remainder >= |b|: subtract and shift in quotient bit 1; otherwise shift in 0.
  - Decrement the counter; after ITER cycles go to FIX.
  - Full ITER cycles are run even when dz=1, so latency is constant.
- FIX (1 cycle), with mag = 24-bit quotient magnitude:
  - ovf = !dz && (sign ? mag > 2^(WIDTH-1) : mag > 2^(WIDTH-1)-1).
  - q = sign ? -mag[WIDTH-1:0] : mag[WIDTH-1:0], subject to the dz and Optional Feature overrides.
  - Register q, div_by_zero=dz, overflow=ovf. Go to DONE.
- DONE:
  - out_valid=1; q and flags held stable while out_valid && !out_ready.
  - On out_ready: out_valid=0 next edge; go to IDLE.
- Latency: acceptance edge + ITER cycles of CALC + 1 cycle of FIX, so out_valid rises on the (ITER+1)th edge after acceptance (25 by default).
- in_ready=0 in CALC, FIX and DONE. in_valid asserted while busy is ignored; the source must hold it.
- Throughput: one operation per ITER+3 cycles minimum (the acceptance edge, ITER CALC cycles, FIX, the DONE handshake cycle, and the return to IDLE).
- Divide-by-zero without the macro: q=0x0000, div_by_zero=1, overflow=0.
- Zero dividend: q=0, no flags; the sign of a zero result is forced positive (never emitted as -0 wrap).
- a=0x8000 is handled through the WIDTH-bit unsigned magnitude; no extra sign bit is needed.

Optional Feature:
- Macro: DIVIDER_SATURATE_EN.
- Defined:
  - When overflow=1, q = 2^(WIDTH-1)-1 (0x7FFF) for a positive result, or -2^(WIDTH-1) (0x8000) for a negative result.
  - Divide-by-zero gives q=0x7FFF if a>=0, or 0x8000 if a<0 (0x0000 / 0 gives 0x7FFF).
- Undefined:
  - On overflow, q = the low WIDTH bits of the signed-wrapped result.
  - Divide-by-zero gives q=0x0000.
- The overflow and div_by_zero flags behave identically in both builds.

Test Plan:
- a=0x0300, b=0x0200 -> q=0x0180 (1.5), flags 0; out_valid exactly 25 edges after acceptance.
- a=0xFD00, b=0x0200 -> q=0xFE80 (-1.5). a=0x0100, b=0x0300 -> q=0x0055 (truncation). a=0xFF00, b=0x0300 -> q=0xFFAB (toward zero).
- a=0x7F00, b=0x0080 -> overflow=1; q=0xFE00 without macro, 0x7FFF with DIVIDER_SATURATE_EN. a=0x8000, b=0xFF00 -> overflow=1; q=0x8000 without macro, 0x7FFF with it.
- a=0xFE00, b=0x0000 -> div_by_zero=1, overflow=0; q=0x0000 without macro, 0x8000 with it.
- Backpressure: hold out_ready=0 for 10 cycles -> q and flags stable, in_ready=0, and a second in_valid is ignored. Release out_ready -> in_ready=1 one edge later, and the second operation is then accepted.
- Pull rst_n low at CALC cycle 10 -> out_valid=0 and in_ready=1 immediately (asynchronously). Release and issue a=0x0100, b=0x0100 -> q=0x0100 with correct latency.
